// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencing controller for an external N x N weight-stationary
// systolic array. It runs one job at a time in four steps:
//   1. Stream N weight rows into the array.
//   2. Spend one flush cycle.
//   3. Stream tile_len activation rows into the array. A row is sent only on
//      a handshake; otherwise a zero bubble row is sent.
//   4. Drain for 2N cycles, so the last result can leave the array.
// A 2N-deep tag shift register marks which array outputs are real result
// rows and which are bubbles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, tile_len       start a job; tile_len = number of activation rows
//   w_valid/w_ready/w_data  weight-row handshake (N*DATA_WIDTH row)
//   a_valid/a_ready/a_data  activation-row handshake (N*DATA_WIDTH row)
//   arr_a, arr_b          array activation / weight operand rows
//   arr_sum_in            array partial-sum input row
//   arr_mode              array mode, tied 0 (weight-stationary)
//   arr_state             0 = weight load, 1 = compute
//   arr_sum_out           column-aligned array result row
//   res_valid, res_data   result strobe and row (no backpressure)
//   busy, done            job in progress / one-cycle end-of-job pulse
//   bias                  (SYSTOLIC_CTRL_BIAS_EN only) latched on start and
//                         driven on arr_sum_in during COMPUTE and DRAIN
//
// Build option: define SYSTOLIC_CTRL_BIAS_EN to add the bias port.
module systolic_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int SUM_WIDTH      = 16,
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [LEN_WIDTH-1:0]                tile_len,
  input  logic                                w_valid,
  output logic                                w_ready,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] w_data,
  input  logic                                a_valid,
  output logic                                a_ready,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] a_data,
`ifdef SYSTOLIC_CTRL_BIAS_EN
  input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  bias,
`endif
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_a,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_b,
  output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  arr_sum_in,
  output logic                                arr_mode,
  output logic                                arr_state,
  input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  arr_sum_out,
  output logic                                res_valid,
  output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  res_data,
  output logic                                busy,
  output logic                                done
);

  localparam int TAG_DEPTH = 2 * SYSTOLIC_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LAST_W = LEN_WIDTH'(SYSTOLIC_WIDTH - 1);
  localparam logic [LEN_WIDTH-1:0] LAST_D = LEN_WIDTH'(TAG_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0] ONE    = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [TAG_DEPTH-1:0]   tag_q, tag_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tag_q   <= tag_d;
    end
  end

  // One counter serves the weight rows, the activation rows and the drain
  // cycles. It is cleared on every state change, so an activation count of
  // 2^LEN_WIDTH-1 ends at len_q-1 and never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    tag_d     = {tag_q[TAG_DEPTH-2:0], 1'b0};
    w_ready   = 1'b0;
    a_ready   = 1'b0;
    arr_a     = '0;
    arr_b     = '0;
    arr_state = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) begin
          len_d   = tile_len;
          state_d = (tile_len == '0) ? DONE : LOAD;
        end
      end

      // Rows go to the array in the order they are accepted. The array
      // shifts them downward, so the first row accepted ends up in row N-1.
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          arr_b = w_data;
          if (cnt_q == LAST_W) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      FLUSH: state_d = COMPUTE;

      COMPUTE: begin
        arr_state = 1'b1;
        a_ready   = 1'b1;
        if (a_valid) begin
          arr_a    = a_data;
          tag_d[0] = 1'b1;
          if (cnt_q == len_q - ONE) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      DRAIN: begin
        arr_state = 1'b1;
        if (cnt_q == LAST_D) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef SYSTOLIC_CTRL_BIAS_EN
  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] bias_q, bias_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q <= '0;
    else        bias_q <= bias_d;
  end

  always_comb begin
    bias_d = bias_q;
    if (state_q == IDLE && start) bias_d = bias;
    arr_sum_in = (state_q == COMPUTE || state_q == DRAIN) ? bias_q : '0;
  end
`else
  assign arr_sum_in = '0;
`endif

  assign arr_mode  = 1'b0;
  assign res_valid = tag_q[TAG_DEPTH-1];
  // res_data is gated with res_valid: no latency is added, and it reads 0
  // while in reset.
  assign res_data  = res_valid ? arr_sum_out : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  tile_len;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic        a_valid, a_ready;
  logic [63:0] a_data;
  logic [63:0] arr_a, arr_b, arr_sum_in, arr_sum_out, res_data;
  logic        arr_mode, arr_state, res_valid, busy, done;
`ifdef SYSTOLIC_CTRL_BIAS_EN
  logic [63:0] bias;
`endif

  systolic_ctrl #(
    .DATA_WIDTH(16), .SUM_WIDTH(16), .SYSTOLIC_WIDTH(4), .LEN_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_len(tile_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
`ifdef SYSTOLIC_CTRL_BIAS_EN
    .bias(bias),
`endif
    .arr_a(arr_a), .arr_b(arr_b), .arr_sum_in(arr_sum_in),
    .arr_mode(arr_mode), .arr_state(arr_state), .arr_sum_out(arr_sum_out),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Array model with identity weights: each output row is the input row
  // (plus the partial-sum input) delayed by 2N = 8 cycles.
  logic [63:0] pipe [8];
  always @(posedge clk) begin
    pipe[0] <= arr_a + arr_sum_in;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign arr_sum_out = pipe[7];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          hs_q[$], res_cyc_q[$], done_q[$];
  logic [63:0] res_dat_q[$];
  int          drain_entry = 0, flush_cnt = 0, wr_seen = 0, ar_seen = 0;
  bit          prev_drain = 1'b0;
  always @(negedge clk) begin
    if (a_valid && a_ready) hs_q.push_back(cyc);
    if (res_valid) begin
      res_cyc_q.push_back(cyc);
      res_dat_q.push_back(res_data);
    end
    if (done) done_q.push_back(cyc);
    if (w_ready) wr_seen++;
    if (a_ready) ar_seen++;
    if (busy && !arr_state && !w_ready && !done) flush_cnt++;
    if (busy && arr_state && !a_ready && !prev_drain) drain_entry = cyc;
    prev_drain = busy && arr_state && !a_ready;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] make_row(input int k);
    return {16'(k + 4), 16'(k + 3), 16'(k + 2), 16'(k + 1)};
  endfunction

  // All stimulus tasks start and end at posedge+1.
  task automatic send_w(input logic [63:0] d);
    int n = 0;
    w_valid = 1'b1; w_data = d;
    #2;
    while (!w_ready && n < 50) begin @(posedge clk); #3; n++; end
    check("w_hs_timeout", 64'(n < 50), 64'd1);
    check("arr_b_drive", arr_b, d);
    @(posedge clk); #1;
    w_valid = 1'b0; w_data = '0;
  endtask

  task automatic send_a(input logic [63:0] d);
    int n = 0;
    a_valid = 1'b1; a_data = d;
    #2;
    while (!a_ready && n < 50) begin @(posedge clk); #3; n++; end
    check("a_hs_timeout", 64'(n < 50), 64'd1);
    check("arr_a_drive", arr_a, d);
`ifndef SYSTOLIC_CTRL_BIAS_EN
    check("arr_sum_in_zero", arr_sum_in, 64'd0);
`endif
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = '0;
  endtask

  task automatic bubble();
    a_data = 64'hdead_beef_dead_beef;
    #2;
    check("bubble_arr_a", arr_a, 64'd0);
    @(posedge clk); #1;
    a_data = '0;
  endtask

  task automatic wait_done(input int db);
    int n = 0;
    while (done_q.size() == db && n < 60) begin @(posedge clk); n++; end
    check("done_timeout", 64'(done_q.size() > db), 64'd1);
    #1;
  endtask

  task automatic run_job(input int len, input bit toggle, input bit stall, input bit full);
    int hb = hs_q.size();
    int rb = res_cyc_q.size();
    int db = done_q.size();
    int fb = flush_cnt;
    start = 1'b1; tile_len = 8'(len);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_w(64'd1 << (16 * (3 - i)));
      if (stall && i == 1) begin
        for (int s = 0; s < 5; s++) begin
          #2;
          check("stall_arr_state", 64'(arr_state), 64'd0);
          check("stall_w_ready", 64'(w_ready), 64'd1);
          @(posedge clk); #1;
        end
      end
    end
    for (int k = 0; k < len; k++) begin
      send_a(make_row(k));
      if (toggle && k != len - 1) bubble();
    end
    wait_done(db);
    check("flush_once", 64'(flush_cnt - fb), 64'd1);
    check("res_count", 64'(res_cyc_q.size() - rb), 64'(len));
    if (done_q.size() > db)
      check("done_after_drain", 64'(done_q[db] - drain_entry), 64'd8);
    if (res_cyc_q.size() - rb >= len && hs_q.size() - hb >= len) begin
      if (full) begin
        for (int k = 0; k < len; k++) begin
          check("res_latency", 64'(res_cyc_q[rb+k] - hs_q[hb+k]), 64'd8);
          check("res_data", res_dat_q[rb+k], make_row(k));
        end
        for (int k = 1; k < len; k++)
          check("res_spacing", 64'(res_cyc_q[rb+k] - res_cyc_q[rb+k-1]),
                toggle ? 64'd2 : 64'd1);
      end else begin
        check("res_last_data", res_dat_q[rb+len-1], make_row(len - 1));
      end
    end
  endtask

  initial begin
    int rb, db, wb, ab, n;
    rst_n = 1'b0; start = 1'b0; tile_len = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
`ifdef SYSTOLIC_CTRL_BIAS_EN
    bias = '0;
`endif
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", {arr_state, arr_mode, w_ready, a_ready, res_valid, done}, 64'd0);
    check("rst_data", arr_a | arr_b | res_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single row, identity weights.
    run_job(1, 1'b0, 1'b0, 1'b1);
    // Three rows with a_valid toggling.
    run_job(3, 1'b1, 1'b0, 1'b1);
    // Weight stall mid-LOAD.
    run_job(2, 1'b0, 1'b1, 1'b1);

    // tile_len = 0 goes straight to DONE.
    wb = wr_seen; ab = ar_seen;
    start = 1'b1; tile_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd1);
    @(posedge clk); #3;
    check("len0_done_clr", {busy, done}, 64'd0);
    check("len0_no_ready", 64'((wr_seen - wb) + (ar_seen - ab)), 64'd0);
    @(posedge clk); #1;

    // A start pulse while busy must be ignored.
    start = 1'b1; tile_len = 8'd2;
    @(posedge clk); #1;
    tile_len = 8'd7;
    @(posedge clk); #1;
    start = 1'b0; tile_len = 8'd0;
    for (int i = 0; i < 4; i++) send_w(64'd1 << (16 * (3 - i)));
    rb = res_cyc_q.size(); db = done_q.size();
    send_a(make_row(0)); send_a(make_row(1));
    wait_done(db);
    check("busy_start_ignored", 64'(res_cyc_q.size() - rb), 64'd2);
    @(posedge clk); #1;

    // Reset during DRAIN.
    start = 1'b1; tile_len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_w(64'd1 << (16 * (3 - i)));
    send_a(make_row(0)); send_a(make_row(1));
    n = 0;
    while (!(busy && arr_state && !a_ready) && n < 20) begin @(posedge clk); #1; n++; end
    check("drain_reached", 64'(n < 20), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {busy, arr_state, w_ready, a_ready, res_valid, done}, 64'd0);
    rb = res_cyc_q.size(); db = done_q.size();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("postrst_no_res", 64'(res_cyc_q.size() - rb), 64'd0);
    check("postrst_no_done", 64'(done_q.size() - db), 64'd0);
    run_job(1, 1'b0, 1'b0, 1'b1);

    // Longest job: tile_len = 255 must not wrap.
    run_job(255, 1'b0, 1'b0, 1'b0);

`ifdef SYSTOLIC_CTRL_BIAS_EN
    bias = {4{16'd10}};
    start = 1'b1; tile_len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; bias = '0;
    for (int i = 0; i < 4; i++) send_w(64'd1 << (16 * (3 - i)));
    rb = res_cyc_q.size(); db = done_q.size();
    send_a(64'd0); send_a(64'd0);
    wait_done(db);
    check("bias_count", 64'(res_cyc_q.size() - rb), 64'd2);
    if (res_cyc_q.size() - rb >= 2) begin
      check("bias_res0", res_dat_q[rb], {4{16'd10}});
      check("bias_res1", res_dat_q[rb+1], {4{16'd10}});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, operand width; SUM_WIDTH, default 16, accumulator/result width; SYSTOLIC_WIDTH (N), default 4, array dimension; LEN_WIDTH, default 8, width of tile_len.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin job; sampled in IDLE only
- tile_len  in  LEN_WIDTH  number of A rows; latched on start
- w_valid/w_ready  in/out  1  weight-row handshake
- w_data  in  N*DATA_WIDTH  one weight row
- a_valid/a_ready  in/out  1  activation-row handshake
- a_data  in  N*DATA_WIDTH  one activation row
- arr_a, arr_b  out  N*DATA_WIDTH  array operand inputs
- arr_sum_in  out  N*SUM_WIDTH  array partial-sum input
- arr_mode  out  1  array mode, constant 0 (weight-stationary)
- arr_state  out  1  0 = weight load, 1 = compute
- arr_sum_out  in  N*SUM_WIDTH  column-aligned array result
- res_valid  out  1  result row valid, one-cycle strobe, no backpressure
- res_data  out  N*SUM_WIDTH  result row
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end

Function
REQ-003 FSM SHALL have states IDLE, LOAD, FLUSH, COMPUTE, DRAIN, DONE.
REQ-004 IDLE: start=1 with tile_len!=0 -> LOAD; start with tile_len=0 -> DONE directly, no array activity.
REQ-005 LOAD: arr_state=0, w_ready=1; each w handshake drives arr_b=w_data that cycle, else arr_b=0; after N handshakes -> FLUSH.
REQ-006 Weight rows SHALL be sent bottom-row first (first accepted row lands in array row N-1).
REQ-007 FLUSH: exactly 1 cycle, arr_state=0, w_ready=0, arr_b=0; -> COMPUTE.
REQ-008 COMPUTE: arr_state=1, a_ready=1; handshake drives arr_a=a_data, else arr_a=0 (bubble); after tile_len handshakes -> DRAIN.
REQ-009 Outside COMPUTE handshake cycles arr_a SHALL be 0; a_ready and w_ready SHALL be 0 outside COMPUTE and LOAD respectively.
REQ-010 Controller SHALL keep a 2N-deep valid-tag shift register; tag in = a handshake in COMPUTE; array latency from arr_a to arr_sum_out is 2N cycles.
REQ-011 res_valid SHALL equal the tag emerging after 2N cycles; res_data = arr_sum_out registered-through combinationally (no added latency); bubble rows SHALL never produce res_valid.
REQ-012 DRAIN: arr_state=1, inputs 0, for exactly 2N cycles after last accepted row; -> DONE.
REQ-013 DONE: done=1 for one cycle, busy=1; -> IDLE. Total res_valid pulses per job SHALL equal tile_len.
REQ-014 Row counters SHALL be LEN_WIDTH bits; tile_len = 2^LEN_WIDTH-1 SHALL complete without wrap.
REQ-015 start while busy SHALL be ignored.

Reset
REQ-016 On rst_n low, asynchronously: state IDLE, counters and tag register 0, all outputs 0 (arr_state=0, arr_mode=0, ready/valid/done/busy=0).
REQ-017 Reset mid-job SHALL abort; no res_valid or done after release until a new start.

Configuration
REQ-018 Macro SYSTOLIC_CTRL_BIAS_EN: when defined, port bias (in, N*SUM_WIDTH) SHALL be latched on start and driven on arr_sum_in during COMPUTE and DRAIN, else 0; when undefined, no bias port and arr_sum_in SHALL be constant 0.

Verification
REQ-019 N=4, tile_len=1, identity weights, a_data row {1,2,3,4} no bubbles -> single res_valid 8 cycles after the handshake, res_data={1,2,3,4}, done 8 cycles after the DRAIN entry.
REQ-020 tile_len=3, a_valid toggling 1/0 -> exactly 3 res_valid pulses spaced 2 cycles apart, correct order.
REQ-021 w_valid stalled 5 cycles mid-LOAD -> arr_state stays 0, FLUSH occurs once after the 4th weight row, results unaffected.
REQ-022 start with tile_len=0 -> done 1 cycle later, w_ready/a_ready never asserted.
REQ-023 rst_n pulsed low during DRAIN -> outputs 0 immediately, no res_valid/done afterward; a new job then completes correctly.
REQ-024 With SYSTOLIC_CTRL_BIAS_EN, bias={10,10,10,10}, all-zero activations -> every res_data column = 10.
